load_store_unit: RTL

Sits between the MIPS datapath and the word-addressed data memory. Converts byte-addressed load/store requests of byte, halfword or word size into word-indexed memory accesses. Performs sign/zero extension on loads and a two-cycle read-modify-write on sub-word stores, stalling the core for one cycle while it does so. Flags misaligned and out-of-range accesses and keeps a saturating fault count.

---
 rtl/load_store_unit_pkg.sv | 33 +++
 rtl/load_store_unit_if.sv | 29 ++
 rtl/load_store_unit_load_extend.sv | 27 ++
 rtl/load_store_unit.sv | 96 +++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared encodings, widths and the sub-word store lane merge helper for the load/store unit.
package load_store_unit_pkg;

  localparam int unsigned DATA_W      = 32;
  localparam int unsigned FAULT_CNT_W = 8;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_BAD  = 2'b11
  } size_e;

  typedef enum logic {
    IDLE  = 1'b0,
    MERGE = 1'b1
  } state_e;

  // Replace the addressed byte/halfword lane of a read word with right-justified store data.
  function automatic logic [DATA_W-1:0] merge_lanes(input logic [DATA_W-1:0] rd,
                                                    input logic [DATA_W-1:0] wdata,
                                                    input size_e             size,
                                                    input logic [1:0]        off);
    logic [DATA_W-1:0] r;
    r = rd;
    if (size == SIZE_BYTE)
      r[{off, 3'b000} +: 8] = wdata[7:0];
    else if (size == SIZE_HALF)
      r[{off[1], 4'b0000} +: 16] = wdata[15:0];
    return r;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core request/response and data-memory signals of the load/store unit.
interface load_store_unit_if;
  import load_store_unit_pkg::*;

  logic                   req_valid;
  logic                   req_we;
  logic [1:0]             req_size;
  logic                   req_unsigned;
  logic [31:0]            req_addr;
  logic [DATA_W-1:0]      req_wdata;
  logic [DATA_W-1:0]      load_data;
  logic                   stall;
  logic                   fault;
  logic [FAULT_CNT_W-1:0] fault_count;
  logic                   mem_WE;
  logic [31:0]            mem_A;
  logic [DATA_W-1:0]      mem_WD;
  logic [DATA_W-1:0]      mem_RD;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_RD,
    input  load_data, stall, fault, fault_count, mem_WE, mem_A, mem_WD
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_RD,
    output load_data, stall, fault, fault_count, mem_WE, mem_A, mem_WD
  );
endinterface

// File: rtl/load_store_unit_load_extend.sv
// Load lane select plus sign/zero extension from a raw memory word.
module load_extend
  import load_store_unit_pkg::*;
(
  input  logic [DATA_W-1:0] rd,
  input  size_e             size,
  input  logic [1:0]        off,
  input  logic              is_unsigned,
  output logic [DATA_W-1:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign byte_lane = rd[{off, 3'b000} +: 8];
  assign half_lane = rd[{off[1], 4'b0000} +: 16];

  always_comb begin
    data = rd;
    case (size)
      SIZE_BYTE: data = is_unsigned ? {24'd0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
      SIZE_HALF: data = is_unsigned ? {16'd0, half_lane} : {{16{half_lane[15]}}, half_lane};
      default:   data = rd;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a word-indexed data memory, with sub-word
// read-modify-write stores and a sticky fault flag plus saturating fault counter.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 100
) (
  input  logic              Load_Store_Unit_CLK,
  input  logic              Load_Store_Unit_RST,
  load_store_unit_if.slave  bus
);

  state_e                 state, next_state;
  logic [DATA_W-1:0]      merged;
  logic                   fault_q;
  logic [FAULT_CNT_W-1:0] fault_cnt;

  size_e             size;
  logic [1:0]        off;
  logic              misaligned_c;
  logic              out_of_range_c;
  logic              bad_c;
  logic              sub_word_c;
  logic [DATA_W-1:0] ext_data;
  logic              stall_c;
  logic              mem_we_c;
  logic [DATA_W-1:0] mem_wd_c;
  logic [DATA_W-1:0] load_data_c;

  assign size           = size_e'(bus.req_size);
  assign off            = bus.req_addr[1:0];
  assign misaligned_c   = ((size == SIZE_HALF) && off[0]) ||
                          ((size == SIZE_WORD) && (off != 2'b00));
  assign out_of_range_c = bus.req_addr[31:2] >= 30'(MEM_DEPTH);
  // Faults are only judged in IDLE; the held request in MERGE is never re-evaluated.
  assign bad_c          = (state == IDLE) && bus.req_valid &&
                          ((size == SIZE_BAD) || misaligned_c || out_of_range_c);
  assign sub_word_c     = (size == SIZE_BYTE) || (size == SIZE_HALF);

  load_extend u_load_extend (
    .rd          (bus.mem_RD),
    .size        (size),
    .off         (off),
    .is_unsigned (bus.req_unsigned),
    .data        (ext_data)
  );

  always_comb begin
    next_state  = state;
    stall_c     = 1'b0;
    mem_we_c    = 1'b0;
    mem_wd_c    = bus.req_wdata;
    load_data_c = '0;
    if (state == MERGE) begin
      mem_we_c   = 1'b1;
      mem_wd_c   = merged;
      next_state = IDLE;
    end else if (bus.req_valid && !bad_c) begin
      if (!bus.req_we) begin
        load_data_c = ext_data;
      end else if (sub_word_c) begin
        stall_c    = 1'b1;
        next_state = MERGE;
      end else begin
        mem_we_c = 1'b1;
      end
    end
  end

  always_ff @(posedge Load_Store_Unit_CLK or negedge Load_Store_Unit_RST) begin
    if (!Load_Store_Unit_RST) begin
      state     <= IDLE;
      merged    <= '0;
      fault_q   <= 1'b0;
      fault_cnt <= '0;
    end else begin
      state <= next_state;
      if (stall_c)
        merged <= merge_lanes(bus.mem_RD, bus.req_wdata, size, off);
      if (bad_c) begin
        fault_q <= 1'b1;
        if (fault_cnt != {FAULT_CNT_W{1'b1}})
          fault_cnt <= fault_cnt + FAULT_CNT_W'(1);
      end
    end
  end

  assign bus.load_data   = load_data_c;
  assign bus.stall       = stall_c;
  assign bus.mem_WE      = mem_we_c;
  assign bus.mem_WD      = mem_wd_c;
  assign bus.mem_A       = {2'b00, bus.req_addr[31:2]};
  assign bus.fault       = fault_q;
  assign bus.fault_count = fault_cnt;

endmodule
